// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: constants and types shared by the control sequencer and
// the instruction decoder.
//   - opcode values carried in instr[6:0]
//   - ALU op codes the decoder reports on dec_alu_op (0 = unrecognised)
//   - sequencer state type
package core_ctrl_pkg;

    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_AND  = 7'h03;
    localparam logic [6:0] OP_OR   = 7'h04;
    localparam logic [6:0] OP_XOR  = 7'h05;
    localparam logic [6:0] OP_SLL  = 7'h06;
    localparam logic [6:0] OP_SRL  = 7'h07;
    localparam logic [6:0] OP_SRA  = 7'h08;
    localparam logic [6:0] OP_SLT  = 7'h09;
    localparam logic [6:0] OP_SLTU = 7'h0A;
    localparam logic [6:0] OP_LW   = 7'h0B;
    localparam logic [6:0] OP_SW   = 7'h0C;
    localparam logic [6:0] OP_HALT = 7'h7F;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LW   = 4'd11;
    localparam logic [3:0] ALU_SW   = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == ALU_LW) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: memory, decoder and datapath-strobe signals around the
// control sequencer.
//   master (sequencer): drives imem_req/imem_addr, dec_instr, rf_rd_en,
//                       alu_en, dmem_req/dmem_we, rf_we, wb_sel
//   slave  (memories/decoder/datapath): drives imem_valid/imem_rdata,
//                       dec_alu_op, dmem_ready
interface core_ctrl_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic [31:0]     dec_instr;
    logic [3:0]      dec_alu_op;
    logic            rf_rd_en;
    logic            alu_en;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;
    logic            rf_we;
    logic            wb_sel;

    modport master (
        output imem_req, imem_addr, dec_instr, rf_rd_en, alu_en,
               dmem_req, dmem_we, rf_we, wb_sel,
        input  imem_valid, imem_rdata, dec_alu_op, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_instr, rf_rd_en, alu_en,
               dmem_req, dmem_we, rf_we, wb_sel,
        output imem_valid, imem_rdata, dec_alu_op, dmem_ready
    );
endinterface

// File: rtl/core_ctrl_perf.sv
// core_ctrl_perf: retired-instruction and busy-cycle counters.
//   clk, rst_n   clock, async active-low reset
//   clear_i      synchronous clear (accepted start)
//   retire_i     one pulse per retired instruction
//   busy_i       sequencer busy
//   retired_o    retired instruction count (wraps at 2^32)
//   cycles_o     busy cycle count (wraps at 2^32)
module core_ctrl_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        retire_i,
    input  logic        busy_i,
    output logic [31:0] retired_o,
    output logic [31:0] cycles_o
);

    logic [31:0] retired_q, retired_d;
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        retired_d = retired_q;
        cycles_d  = cycles_q;
        if (clear_i) begin
            retired_d = '0;
            cycles_d  = '0;
        end else begin
            if (retire_i) retired_d = retired_q + 32'd1;
            if (busy_i)   cycles_d  = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign retired_o = retired_q;
    assign cycles_o  = cycles_q;

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle control sequencer. Fetches an instruction, hands it
// to the decoder, then steps the datapath through EXEC / MEM / WB and
// advances the PC. Halts on the HALT opcode or an unrecognised opcode.
//
// Optional build macro CORE_CTRL_PERF_EN: when defined, retired/cycles are
// live counters (core_ctrl_perf); otherwise they are tied to zero.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             begin execution at RESET_PC (only in IDLE/HALT)
//   bus (master)      imem / decoder / dmem / datapath strobes
//   busy              not in IDLE or HALT
//   halted            in HALT
//   illegal           sticky, halted on an unrecognised opcode
//   retired, cycles   performance counters
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem_req held until imem_valid, instruction latched
// DECODE | register read; opcode picks HALT or EXEC
// EXEC   | ALU evaluate; LW/SW go to MEM, everything else to WB
// MEM    | dmem_req held until dmem_ready; SW retires here
// WB     | register write, retire
// HALT   | stopped, waiting for start
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    core_ctrl_if.master bus,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [31:0] cycles
);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [3:0]      op_q, op_d;
    logic            illegal_q, illegal_d;
    logic            retire;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retire    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = RESET_PC;
                    illegal_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The decoder op is captured here so that dmem_we and wb_sel
                // later come from a register, not from the decoder input.
                op_d = bus.dec_alu_op;
                if (instr_q[6:0] == OP_HALT) begin
                    state_d = S_HALT;
                end else if (bus.dec_alu_op == ALU_NONE) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = is_mem_op(op_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (op_q == ALU_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            op_q      <= ALU_NONE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Every output is a decode of registered state only.
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.dec_instr = instr_q;
    assign bus.rf_rd_en  = (state_q == S_DECODE);
    assign bus.alu_en    = (state_q == S_EXEC);
    assign bus.dmem_req  = (state_q == S_MEM);
    assign bus.dmem_we   = (state_q == S_MEM) && (op_q == ALU_SW);
    assign bus.rf_we     = (state_q == S_WB);
    assign bus.wb_sel    = (state_q == S_WB) && (op_q == ALU_LW);

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

`ifdef CORE_CTRL_PERF_EN
    logic perf_clear;
    assign perf_clear = start && !busy;

    core_ctrl_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (perf_clear),
        .retire_i  (retire),
        .busy_i    (busy),
        .retired_o (retired),
        .cycles_o  (cycles)
    );
`else
    assign retired = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl. The reference is a per-instruction cost
// model: cycles = fetch waits + fixed phase count + memory waits, plus the
// expected strobe counts, PC and counter values derived from the opcode.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
`ifdef CORE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, halted, illegal;
    logic [31:0] retired, cycles;

    core_ctrl_if #(.PC_W(32)) bus ();

    always #5 clk = ~clk;

    // Reference decoder: opcodes 1..12 map to ALU ops 1..12, anything else 0.
    assign bus.dec_alu_op = (bus.dec_instr[6:0] >= 7'd1 && bus.dec_instr[6:0] <= 7'd12)
                            ? bus.dec_instr[3:0] : 4'd0;

    core_ctrl #(.PC_W(32), .RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired),
        .cycles  (cycles)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_m;
    logic [31:0] ret_m;
    logic [31:0] cyc_m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or HALT.
    task automatic do_start();
        start          = 1'b1;
        bus.imem_valid = 1'b0;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pc_m  = RST_PC;
        ret_m = '0;
        cyc_m = '0;
        check_val("start_busy",    32'(busy), 32'd1);
        check_val("start_illegal", 32'(illegal), 32'd0);
        check_val("start_halted",  32'(halted), 32'd0);
        check_val("start_pc",      bus.imem_addr, RST_PC);
        check_val("start_retired", retired, 32'd0);
        check_val("start_cycles",  cycles, 32'd0);
    endtask

    // Called at a negedge with the DUT in its first FETCH cycle of an
    // instruction. Returns at the negedge of the next FETCH, or in HALT.
    task automatic run_instr(input logic [6:0] opc, input int iw, input int dw);
        bit          is_halt = (opc == 7'h7F);
        bit          legal   = (opc >= 7'd1) && (opc <= 7'd12);
        bit          is_lw   = (opc == 7'd11);
        bit          is_sw   = (opc == 7'd12);
        int          exp_cyc;
        int          cyc = 0, fcnt = 0, mcnt = 0;
        int          n_rd = 0, n_alu = 0, n_dreq = 0, n_dwe = 0, n_rfwe = 0, n_wbs = 0;
        bit          left_fetch = 1'b0;
        bit          ended = 1'b0;
        logic [31:0] word;

        word      = $urandom;
        word[6:0] = opc;
        exp_cyc   = iw + 2;
        if (legal)
            exp_cyc += 1 + ((is_lw || is_sw) ? dw + 1 : 0) + (is_sw ? 0 : 1);

        check_val("fetch_req",  32'(bus.imem_req), 32'd1);
        check_val("fetch_addr", bus.imem_addr, pc_m);

        for (int it = 0; it < 64; it++) begin
            if (!busy || (left_fetch && bus.imem_req)) begin
                ended = 1'b1;
                break;
            end
            cyc++;
            if (!bus.imem_req) left_fetch = 1'b1;
            if (bus.rf_rd_en) begin
                n_rd++;
                check_val("dec_instr", bus.dec_instr, word);
            end
            if (bus.alu_en)   n_alu++;
            if (bus.dmem_req) n_dreq++;
            if (bus.dmem_we)  n_dwe++;
            if (bus.rf_we)    n_rfwe++;
            if (bus.wb_sel)   n_wbs++;

            if (bus.imem_req) begin
                fcnt++;
                bus.imem_valid = (fcnt > iw);
                bus.imem_rdata = bus.imem_valid ? word : $urandom;
            end else begin
                bus.imem_valid = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
            end
            if (bus.dmem_req) begin
                mcnt++;
                bus.dmem_ready = (mcnt > dw);
            end else begin
                bus.dmem_ready = 1'($urandom_range(0, 1));
            end
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;

        check_val("ended",     32'(ended), 32'd1);
        check_val("cpi",       32'(cyc), 32'(exp_cyc));
        check_val("n_rf_rd",   32'(n_rd), 32'd1);
        check_val("n_alu_en",  32'(n_alu), legal ? 32'd1 : 32'd0);
        check_val("n_dmem_req",32'(n_dreq), (is_lw || is_sw) ? 32'(dw + 1) : 32'd0);
        check_val("n_dmem_we", 32'(n_dwe), is_sw ? 32'(dw + 1) : 32'd0);
        check_val("n_rf_we",   32'(n_rfwe), (legal && !is_sw) ? 32'd1 : 32'd0);
        check_val("n_wb_sel",  32'(n_wbs), is_lw ? 32'd1 : 32'd0);
        check_val("instr_hold",bus.dec_instr, word);

        if (legal) begin
            pc_m  = pc_m + 32'd4;
            ret_m = ret_m + 32'd1;
        end
        cyc_m = cyc_m + 32'(exp_cyc);

        check_val("halted",  32'(halted), legal ? 32'd0 : 32'd1);
        if (!legal) check_val("illegal", 32'(illegal), is_halt ? 32'd0 : 32'd1);
        check_val("pc",      bus.imem_addr, pc_m);
        check_val("retired", retired, PERF ? ret_m : 32'd0);
        check_val("cycles",  cycles,  PERF ? cyc_m : 32'd0);
    endtask

    initial begin
        logic [6:0] opc;
        int         r;
        bit         reached;

        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        pc_m  = RST_PC;
        ret_m = '0;
        cyc_m = '0;

        repeat (3) @(negedge clk);
        check_val("rst_addr",    bus.imem_addr, RST_PC);
        check_val("rst_busy",    32'(busy), 32'd0);
        check_val("rst_halted",  32'(halted), 32'd0);
        check_val("rst_illegal", 32'(illegal), 32'd0);
        check_val("rst_imem_req",32'(bus.imem_req), 32'd0);
        check_val("rst_dmem_req",32'(bus.dmem_req), 32'd0);
        check_val("rst_rf_we",   32'(bus.rf_we), 32'd0);
        check_val("rst_instr",   bus.dec_instr, 32'd0);
        check_val("rst_retired", retired, 32'd0);
        check_val("rst_cycles",  cycles, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'd0);

        // Directed: ADD (PC wraps on the second retire), LW with slow memory,
        // SW, LW with slow fetch, then an unrecognised opcode.
        do_start();
        run_instr(OP_ADD, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_LW, 2, 0);
        run_instr(7'h30, 0, 0);

        // Three ADDs then HALT from a fresh start: 3*4 + 2 busy cycles.
        do_start();
        run_instr(OP_ADD, 0, 0);
        run_instr(OP_ADD, 0, 0);
        run_instr(OP_ADD, 0, 0);
        run_instr(OP_HALT, 0, 0);
        check_val("halt_retired", retired, PERF ? 32'd3 : 32'd0);
        check_val("halt_cycles",  cycles,  PERF ? 32'd14 : 32'd0);

        // Randomized program.
        do_start();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 19);
            if (r < 16)      opc = 7'($urandom_range(1, 12));
            else if (r < 18) opc = 7'($urandom_range(13, 126));
            else             opc = OP_HALT;
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
            if (halted) do_start();
        end

        // Reset in the middle of a stalled LW memory access.
        bus.imem_valid = 1'b1;
        bus.imem_rdata = {25'h0, OP_LW};
        bus.dmem_ready = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.dmem_req) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("mem_reached", 32'(reached), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_val("arst_busy",     32'(busy), 32'd0);
        check_val("arst_pc",       bus.imem_addr, RST_PC);
        check_val("arst_instr",    bus.dec_instr, 32'd0);
        check_val("arst_retired",  retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
